// File: rtl/lcd_nibble_writer.sv
// Character-LCD writer: accepts one byte per CPU handshake and sends it as two
// 4-bit nibble writes. Runs the power-up and 4-bit init sequence after reset.
module lcd_nibble_writer #(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 12,
  parameter int T_HOLD    = 1,
  parameter int T_NIBGAP  = 50,
  parameter int T_BYTE    = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int CNT_W     = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRegisterSelect,
  input  logic       iData_Ready,
  output logic       oReadyForData,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  // Handshake: a byte is taken on the rising edge where iData_Ready and
  // oReadyForData are both 1; requests while oReadyForData is 0 are dropped.

  localparam logic [2:0] PWRUP = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] PULSE = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] stateLen;
  logic [CNT_W-1:0] waitLen;
  logic             done;

  // initIdx 0..3 walks the single init nibbles, 4..7 the config bytes.
  logic [2:0] initIdx;
  logic       inInit;
  logic       lowNib;
  logic [7:0] byteReg;
  logic       singleNib;
  logic       isClearCmd;
  logic [7:0] nextCfg;

  function automatic logic [7:0] cfgByte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h28;
      2'd1:    b = 8'h06;
      2'd2:    b = 8'h0C;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  assign singleNib  = inInit && !initIdx[2];
  assign isClearCmd = !oLCD_RegisterSelect && (byteReg == 8'h01 || byteReg == 8'h02);
  // From initIdx 3 the +1 wraps to config byte 0; from 4+k it selects byte k+1.
  assign nextCfg    = cfgByte(initIdx[1:0] + 2'd1);

  always_comb begin
    waitLen = CNT_W'(T_BYTE);
    if (singleNib) begin
      case (initIdx[1:0])
        2'd0:    waitLen = CNT_W'(T_INIT1);
        2'd1:    waitLen = CNT_W'(T_INIT2);
        default: waitLen = CNT_W'(T_BYTE);
      endcase
    end else if (!lowNib) begin
      waitLen = CNT_W'(T_NIBGAP);
    end else if (isClearCmd) begin
      waitLen = CNT_W'(T_CLEAR);
    end
  end

  always_comb begin
    stateLen = CNT_W'(1);
    case (state)
      PWRUP:   stateLen = CNT_W'(T_POWERUP);
      SETUP:   stateLen = CNT_W'(T_SETUP);
      PULSE:   stateLen = CNT_W'(T_EN);
      HOLD:    stateLen = CNT_W'(T_HOLD);
      WAIT:    stateLen = waitLen;
      default: stateLen = CNT_W'(1);
    endcase
  end

  assign done = (counter == stateLen - CNT_W'(1));

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state               <= PWRUP;
      counter             <= '0;
      initIdx             <= 3'd0;
      inInit              <= 1'b1;
      lowNib              <= 1'b0;
      byteReg             <= 8'h00;
      oReadyForData       <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= 4'h0;
    end else begin
      counter <= counter + CNT_W'(1);
      case (state)
        PWRUP: begin
          if (done) begin
            counter   <= '0;
            oLCD_Data <= 4'h3;
            state     <= SETUP;
          end
        end

        IDLE: begin
          counter <= '0;
          if (iData_Ready && oReadyForData) begin
            byteReg             <= iData;
            lowNib              <= 1'b0;
            oLCD_Data           <= iData[7:4];
            oLCD_RegisterSelect <= iRegisterSelect;
            oReadyForData       <= 1'b0;
            state               <= SETUP;
          end
        end

        SETUP: begin
          if (done) begin
            counter      <= '0;
            oLCD_Enabled <= 1'b1;
            state        <= PULSE;
          end
        end

        PULSE: begin
          if (done) begin
            counter      <= '0;
            oLCD_Enabled <= 1'b0;
            state        <= HOLD;
          end
        end

        HOLD: begin
          if (done) begin
            counter <= '0;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (done) begin
            counter <= '0;
            if (singleNib && initIdx != 3'd3) begin
              initIdx   <= initIdx + 3'd1;
              oLCD_Data <= (initIdx == 3'd2) ? 4'h2 : 4'h3;
              state     <= SETUP;
            end else if (singleNib || (inInit && lowNib && initIdx != 3'd7)) begin
              initIdx   <= initIdx + 3'd1;
              byteReg   <= nextCfg;
              lowNib    <= 1'b0;
              oLCD_Data <= nextCfg[7:4];
              state     <= SETUP;
            end else if (!lowNib) begin
              lowNib    <= 1'b1;
              oLCD_Data <= byteReg[3:0];
              state     <= SETUP;
            end else begin
              inInit        <= 1'b0;
              oReadyForData <= 1'b1;
              state         <= IDLE;
            end
          end
        end

        default: begin
          counter <= '0;
          state   <= PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with shortened timing parameters.
// A negedge monitor records every E pulse (data, RS, rise cycle, width).
module tb_lcd_nibble_writer;

  localparam int T_POWERUP = 20;
  localparam int T_INIT1   = 10;
  localparam int T_INIT2   = 5;
  localparam int T_BYTE    = 8;
  localparam int T_CLEAR   = 30;
  localparam int T_NIBGAP  = 4;
  localparam int T_SETUP   = 2;
  localparam int T_EN      = 3;
  localparam int T_HOLD    = 1;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iRegisterSelect = 1'b0;
  logic       iData_Ready = 1'b0;
  logic       oReadyForData;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_ReadWrite;
  logic       oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_nibble_writer #(
    .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
    .T_NIBGAP(T_NIBGAP), .T_BYTE(T_BYTE), .T_CLEAR(T_CLEAR),
    .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .CNT_W(20)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iData(iData),
    .iRegisterSelect(iRegisterSelect),
    .iData_Ready(iData_Ready),
    .oReadyForData(oReadyForData),
    .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_Data(oLCD_Data)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // monitor
  logic [3:0] obsData[$];
  logic       obsRs[$];
  int         obsRise[$];
  int         obsWidth[$];
  logic [3:0] exp_q[$];
  logic       prevE = 1'b0;
  logic       prevReady = 1'b0;
  logic [3:0] riseData = 4'h0;
  logic       riseRs = 1'b0;
  int         lastRise = 0;
  int         lastFall = 0;
  int         readyRise = 0;
  int         violations = 0;

  always @(negedge Clock) begin
    if (oLCD_Enabled === 1'b1 && !prevE) begin
      obsData.push_back(oLCD_Data);
      obsRs.push_back(oLCD_RegisterSelect);
      obsRise.push_back(cyc);
      riseData = oLCD_Data;
      riseRs   = oLCD_RegisterSelect;
      lastRise = cyc;
    end
    if (oLCD_Enabled === 1'b1 && prevE &&
        (oLCD_Data !== riseData || oLCD_RegisterSelect !== riseRs)) violations++;
    if (oLCD_Enabled === 1'b1 && oReadyForData === 1'b1) violations++;
    if (oLCD_Enabled !== 1'b1 && prevE) begin
      obsWidth.push_back(cyc - lastRise);
      lastFall = cyc;
    end
    if (oReadyForData === 1'b1 && !prevReady) readyRise = cyc;
    prevE     = (oLCD_Enabled === 1'b1);
    prevReady = (oReadyForData === 1'b1);
  end

  task automatic clear_monitor();
    obsData.delete();
    obsRs.delete();
    obsRise.delete();
    obsWidth.delete();
    exp_q.delete();
    violations = 0;
  endtask

  // driver tasks / scenarios
  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    checks++; if (oLCD_Enabled !== 1'b0) begin fails++; $display("FAIL reset_e got %b want 0", oLCD_Enabled); end
    checks++; if (oLCD_Data !== 4'h0) begin fails++; $display("FAIL reset_data got %h want 0", oLCD_Data); end
    checks++; if (oLCD_RegisterSelect !== 1'b0) begin fails++; $display("FAIL reset_rs got %b want 0", oLCD_RegisterSelect); end
    checks++; if (oReadyForData !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", oReadyForData); end
    checks++; if (oLCD_ReadWrite !== 1'b0) begin fails++; $display("FAIL reset_rw got %b want 0", oLCD_ReadWrite); end
    checks++; if (oLCD_StrataFlashControl !== 1'b1) begin fails++; $display("FAIL reset_sf got %b want 1", oLCD_StrataFlashControl); end
  endtask

  // Expects Reset low on entry; releases it and checks the whole init run.
  task automatic test_init();
    int rel;
    int n;
    int gaps[$];
    clear_monitor();
    exp_q = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    gaps = '{T_EN + T_HOLD + T_INIT1 + T_SETUP, T_EN + T_HOLD + T_INIT2 + T_SETUP,
             T_EN + T_HOLD + T_BYTE + T_SETUP,  T_EN + T_HOLD + T_BYTE + T_SETUP,
             T_EN + T_HOLD + T_NIBGAP + T_SETUP, T_EN + T_HOLD + T_BYTE + T_SETUP,
             T_EN + T_HOLD + T_NIBGAP + T_SETUP, T_EN + T_HOLD + T_BYTE + T_SETUP,
             T_EN + T_HOLD + T_NIBGAP + T_SETUP, T_EN + T_HOLD + T_BYTE + T_SETUP,
             T_EN + T_HOLD + T_NIBGAP + T_SETUP};
    @(posedge Clock); #1;
    Reset = 1'b1;
    rel = cyc + 1;
    n = 0;
    while (oReadyForData !== 1'b1 && n < 3000) begin @(negedge Clock); #1; n++; end
    checks++; if (oReadyForData !== 1'b1) begin fails++; $display("FAIL init_timeout ready=%b after %0d cycles", oReadyForData, n); end
    checks++; if (obsData.size() != 12) begin fails++; $display("FAIL init_pulse_count got %0d want 12", obsData.size()); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= obsData.size() || obsData[i] !== exp_q[i] || obsRs[i] !== 1'b0 || obsWidth[i] != T_EN) begin
        fails++;
        $display("FAIL init_nibble%0d got data=%h rs=%b width=%0d want data=%h rs=0 width=%0d",
                 i, (i < obsData.size()) ? obsData[i] : 4'hx, (i < obsRs.size()) ? obsRs[i] : 1'bx,
                 (i < obsWidth.size()) ? obsWidth[i] : -1, exp_q[i], T_EN);
      end
    end
    checks++;
    if (obsRise.size() < 1 || obsRise[0] != rel + T_POWERUP + T_SETUP - 1) begin
      fails++; $display("FAIL init_first_rise got %0d want %0d", (obsRise.size() > 0) ? obsRise[0] - rel : -1, T_POWERUP + T_SETUP - 1);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i + 1 >= obsRise.size() || obsRise[i+1] - obsRise[i] != gaps[i]) begin
        fails++; $display("FAIL init_gap%0d got %0d want %0d", i, (i + 1 < obsRise.size()) ? obsRise[i+1] - obsRise[i] : -1, gaps[i]);
      end
    end
    checks++; if (readyRise - lastFall != T_HOLD + T_CLEAR) begin fails++; $display("FAIL init_clear_wait got %0d want %0d", readyRise - lastFall, T_HOLD + T_CLEAR); end
    checks++; if (violations != 0) begin fails++; $display("FAIL init_stability got %0d violations want 0", violations); end
  endtask

  task automatic test_data_byte();
    int acc;
    int n;
    clear_monitor();
    exp_q = '{4'h4, 4'h1};
    iData = 8'h41; iRegisterSelect = 1'b1; iData_Ready = 1'b1;
    acc = cyc + 1;
    @(negedge Clock); #1;
    iData_Ready = 1'b0;
    checks++; if (oReadyForData !== 1'b0) begin fails++; $display("FAIL byte_ready_fall got %b want 0", oReadyForData); end
    n = 0;
    while (oReadyForData !== 1'b1 && n < 500) begin @(negedge Clock); #1; n++; end
    checks++; if (oReadyForData !== 1'b1) begin fails++; $display("FAIL byte_timeout ready=%b", oReadyForData); end
    checks++; if (obsData.size() != 2) begin fails++; $display("FAIL byte_pulse_count got %0d want 2", obsData.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= obsData.size() || obsData[i] !== exp_q[i] || obsRs[i] !== 1'b1 || obsWidth[i] != T_EN) begin
        fails++; $display("FAIL byte_nibble%0d got data=%h want data=%h rs=1 width=%0d", i,
                          (i < obsData.size()) ? obsData[i] : 4'hx, exp_q[i], T_EN);
      end
    end
    checks++; if (obsRise.size() < 1 || obsRise[0] - acc != T_SETUP) begin fails++; $display("FAIL byte_first_rise got %0d want %0d", (obsRise.size() > 0) ? obsRise[0] - acc : -1, T_SETUP); end
    checks++; if (obsRise.size() < 2 || obsRise[1] - obsRise[0] != 10) begin fails++; $display("FAIL byte_nib_gap got %0d want 10", (obsRise.size() > 1) ? obsRise[1] - obsRise[0] : -1); end
    checks++; if (readyRise - lastFall != T_HOLD + T_BYTE) begin fails++; $display("FAIL byte_post_wait got %0d want %0d", readyRise - lastFall, T_HOLD + T_BYTE); end
    checks++; if (violations != 0) begin fails++; $display("FAIL byte_stability got %0d violations want 0", violations); end
  endtask

  task automatic test_ignored_request();
    int n;
    clear_monitor();
    exp_q = '{4'h9, 4'h6};
    iData = 8'h96; iRegisterSelect = 1'b1; iData_Ready = 1'b1;
    @(negedge Clock); #1;
    iData_Ready = 1'b0;
    n = 0;
    while (oLCD_Enabled !== 1'b1 && n < 50) begin @(negedge Clock); #1; n++; end
    iData = 8'h55; iRegisterSelect = 1'b0; iData_Ready = 1'b1;
    @(negedge Clock); #1;
    iData_Ready = 1'b0;
    repeat (8) @(negedge Clock);
    #1;
    iData_Ready = 1'b1;
    @(negedge Clock); #1;
    iData_Ready = 1'b0;
    n = 0;
    while (oReadyForData !== 1'b1 && n < 500) begin @(negedge Clock); #1; n++; end
    repeat (6) @(negedge Clock);
    #1;
    checks++; if (oReadyForData !== 1'b1) begin fails++; $display("FAIL ignored_ready got %b want 1", oReadyForData); end
    checks++; if (obsData.size() != 2) begin fails++; $display("FAIL ignored_pulse_count got %0d want 2", obsData.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= obsData.size() || obsData[i] !== exp_q[i] || obsRs[i] !== 1'b1) begin
        fails++; $display("FAIL ignored_nibble%0d got %h want %h", i, (i < obsData.size()) ? obsData[i] : 4'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_clear_timing();
    logic [7:0] bytes[3];
    logic       rsv[3];
    int         waits[3];
    int         n;
    bytes = '{8'h01, 8'h01, 8'h02};
    rsv   = '{1'b0, 1'b1, 1'b0};
    waits = '{T_HOLD + T_CLEAR, T_HOLD + T_BYTE, T_HOLD + T_CLEAR};
    for (int k = 0; k < 3; k++) begin
      clear_monitor();
      iData = bytes[k]; iRegisterSelect = rsv[k]; iData_Ready = 1'b1;
      @(negedge Clock); #1;
      iData_Ready = 1'b0;
      n = 0;
      while (oReadyForData !== 1'b1 && n < 500) begin @(negedge Clock); #1; n++; end
      checks++;
      if (obsData.size() != 2 || obsData[0] !== bytes[k][7:4] || obsData[1] !== bytes[k][3:0] || obsRs[1] !== rsv[k]) begin
        fails++; $display("FAIL clear%0d_nibbles got count=%0d want 2 nibbles of %h rs=%b", k, obsData.size(), bytes[k], rsv[k]);
      end
      checks++;
      if (readyRise - lastFall != waits[k]) begin
        fails++; $display("FAIL clear%0d_wait got %0d want %0d", k, readyRise - lastFall, waits[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_monitor();
    exp_q = '{4'h3, 4'hA, 4'h3, 4'hA};
    iData = 8'h3A; iRegisterSelect = 1'b1; iData_Ready = 1'b1;
    n = 0;
    while (obsData.size() < 3 && n < 500) begin @(negedge Clock); #1; n++; end
    iData_Ready = 1'b0;
    n = 0;
    while (oReadyForData !== 1'b1 && n < 500) begin @(negedge Clock); #1; n++; end
    checks++; if (obsData.size() != 4) begin fails++; $display("FAIL b2b_pulse_count got %0d want 4", obsData.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obsData.size() || obsData[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_nibble%0d got %h want %h", i, (i < obsData.size()) ? obsData[i] : 4'hx, exp_q[i]);
      end
    end
    checks++;
    if (obsRise.size() < 3 || obsRise[2] - obsRise[1] != T_EN + T_HOLD + T_BYTE + 1 + T_SETUP) begin
      fails++; $display("FAIL b2b_gap got %0d want %0d", (obsRise.size() > 2) ? obsRise[2] - obsRise[1] : -1, T_EN + T_HOLD + T_BYTE + 1 + T_SETUP);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    clear_monitor();
    iData = 8'h77; iRegisterSelect = 1'b1; iData_Ready = 1'b1;
    @(negedge Clock); #1;
    iData_Ready = 1'b0;
    n = 0;
    while (oLCD_Enabled !== 1'b1 && n < 50) begin @(negedge Clock); #1; n++; end
    checks++; if (oLCD_Enabled !== 1'b1) begin fails++; $display("FAIL midrst_no_pulse e=%b", oLCD_Enabled); end
    Reset = 1'b0;
    @(negedge Clock); #1;
    checks++; if (oLCD_Enabled !== 1'b0) begin fails++; $display("FAIL midrst_e got %b want 0", oLCD_Enabled); end
    checks++; if (oReadyForData !== 1'b0) begin fails++; $display("FAIL midrst_ready got %b want 0", oReadyForData); end
    checks++; if (oLCD_Data !== 4'h0 || oLCD_RegisterSelect !== 1'b0) begin fails++; $display("FAIL midrst_bus got data=%h rs=%b want 0 0", oLCD_Data, oLCD_RegisterSelect); end
    repeat (2) @(negedge Clock);
    test_init();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_data_byte();
    test_ignored_request();
    test_clear_timing();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_writer.md
Name: lcd_nibble_writer

Overview:
- Responder side of the CPU-to-LCD byte handshake: accepts one byte per handshake and emits it as two 4-bit nibble writes on the character LCD bus.
- The ALU's LCD instruction drives iData/iData_Ready; its BNLCD branch polls oReadyForData.
- After reset the block runs the LCD power-up and 4-bit init sequence autonomously.
- No busy-flag read-back; all LCD timing comes from cycle counters at 50 MHz.

Parameters:
- T_POWERUP, 750000, cycles of wait after reset before the first init nibble (15 ms).
- T_SETUP, 2, cycles with data/RS stable before E rises (40 ns).
- T_EN, 12, cycles E is held high (240 ns).
- T_HOLD, 1, cycles data/RS held after E falls.
- T_NIBGAP, 50, cycles between the high and low nibble of one byte (1 us).
- T_BYTE, 2000, cycles after a normal byte completes (40 us).
- T_CLEAR, 82000, cycles after command byte 0x01 or 0x02 (1.64 ms).
- T_INIT1, 205000, cycles after the first init nibble (4.1 ms).
- T_INIT2, 5000, cycles after the second init nibble (100 us).
- CNT_W, 20, width of the timing counter; must hold the largest T_*.

Ports:
- Clock  in  1  system clock, 50 MHz; all logic is on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- iData  in  8  byte to write.
- iRegisterSelect  in  1  0 = command, 1 = character data; sampled with iData.
- iData_Ready  in  1  request strobe from the CPU.
- oReadyForData  out  1  high when a byte can be accepted.
- oLCD_Enabled  out  1  LCD E pulse.
- oLCD_RegisterSelect  out  1  LCD RS.
- oLCD_ReadWrite  out  1  tied 0 (write only).
- oLCD_StrataFlashControl  out  1  tied 1 (StrataFlash disabled).
- oLCD_Data  out  4  LCD DB[7:4].

Behaviour:
- Reset (Reset==0 at a rising edge):
  - Outputs: oLCD_Enabled=0, oLCD_Data=0, oLCD_RegisterSelect=0, oReadyForData=0.
  - State: state=PWRUP, counter=0, init index=0.
  - Reset mid-transfer aborts the transfer immediately; E drops on the same edge and the captured byte is discarded.
- All outputs are registered.
- Nibble write micro-sequence, common to every nibble:
  - SETUP: drive oLCD_Data and RS, E=0, for T_SETUP cycles.
  - PULSE: E=1 for exactly T_EN cycles.
  - HOLD: E=0, data and RS unchanged, for T_HOLD cycles.
  - WAIT: data and RS unchanged, for the wait specific to that nibble.
- Waits are exact cycle counts: counter loads 0 on state entry; exit when counter==T-1.
- Init sequence after PWRUP expires. All init nibbles and bytes use RS=0.
  - Nibbles 0x3, 0x3, 0x3, 0x2, each followed by T_INIT1, T_INIT2, T_BYTE, T_BYTE respectively.
  - Then config bytes 0x28, 0x06, 0x0C, 0x01, each sent as a full byte (high nibble, T_NIBGAP, low nibble).
  - Post-byte wait is T_BYTE, except T_CLEAR after 0x01.
- Then IDLE: oReadyForData=1.
- Handshake:
  - A byte is accepted on the rising edge where iData_Ready==1 and oReadyForData==1.
  - On that edge iData and iRegisterSelect are captured, oReadyForData goes to 0, and state goes to SETUP of the high nibble. The first E rise is T_SETUP cycles later.
  - iData_Ready while oReadyForData==0 is ignored; there is no queue and no error flag.
  - iData_Ready held high continuously causes back-to-back bytes as soon as ready returns.
- Byte sequence:
  - High nibble iData[7:4], wait T_NIBGAP.
  - Low nibble iData[3:0], wait T_BYTE, or T_CLEAR if RS==0 and the byte is 0x01 or 0x02.
  - Then IDLE with oReadyForData=1.
- RS is held at the captured value from the first SETUP through the end of the final wait.
- Counter never wraps: it is cleared on every state transition.
- oReadyForData is never 1 during init or during any transfer state.

Test Plan:
- Parameters for all scenarios: T_POWERUP=20, T_INIT1=10, T_INIT2=5, T_BYTE=8, T_CLEAR=30, T_NIBGAP=4, T_SETUP=2, T_EN=3, T_HOLD=1.
- Init: release Reset -> exactly 12 E pulses (4 init nibbles + 8 config nibbles) with data sequence 3,3,3,2,2,8,0,6,0,C,0,1. RS=0 throughout. Each E pulse is 3 cycles wide. oReadyForData rises only after the 30-cycle post-clear wait.
- Data byte: after init, iData=0x41, iRegisterSelect=1, iData_Ready one cycle -> oReadyForData falls the next cycle. E pulses with data 4 then 1, RS=1. High-nibble E rise to low-nibble E rise = 3+1+4+2 = 10 cycles. oReadyForData returns exactly 8 cycles after the low nibble's HOLD.
- Ignored request: pulse iData_Ready with 0x55 mid-transfer -> no extra E pulses, transmitted nibbles unchanged.
- Clear timing: command 0x01 with RS=0 -> post-byte wait is 30 cycles, not 8.
- Reset mid-pulse: assert Reset while E=1 -> E=0, oReadyForData=0 on the next edge. After release the full init sequence repeats from PWRUP.
